vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single write port of the 160x120 VGA adapter between NUM_REQ note-lane drawers and one full-screen clear requester.
- A lane request is a BOX_W x BOX_H rectangle at an origin, drawn in one colour. A clear request fills the whole screen with CLEAR_COLOUR.
- Sits between the game datapath (lane draw/erase logic) and the VGA adapter's x/y/colour/plot inputs.
- Sequences the rectangle one pixel per cycle, clips off-screen pixels, and returns a per-requester done pulse.

Parameters:
- NUM_REQ, 4, number of lane requesters
- BOX_W, 4, rectangle width in pixels (1..16)
- BOX_H, 2, rectangle height in pixels (1..16)
- SCR_W, 160, screen width
- SCR_H, 120, screen height
- CLEAR_COLOUR, 3'b000, fill colour for clear

Ports:
- clk  in  1  system clock (50 MHz)
- resetn  in  1  reset; asynchronous, active-high
- req  in  NUM_REQ  per-lane draw request, level, held until done
- req_x  in  8*NUM_REQ  origin x, lane i at bits [8i+7:8i]
- req_y  in  7*NUM_REQ  origin y, lane i at bits [7i+6:7i]
- req_colour  in  3*NUM_REQ  colour, lane i at bits [3i+2:3i]
- clear_req  in  1  full-screen clear request, level, held until clear_done
- pause  in  1  stall: no grants, no pixel advance
- done  out  NUM_REQ  one-cycle pulse on the granted lane's bit when its rectangle completes
- clear_done  out  1  one-cycle pulse when the clear completes
- busy  out  1  high in DRAW and DONE
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write enable to the adapter

Behaviour:
- Reset (async, resetn=1): state IDLE; all outputs 0; counters cx and cy 0; last_grant = NUM_REQ-1, so lane 0 has top priority after reset.
- Reset asserted mid-draw aborts immediately. No done or clear_done pulse is produced.
- States: IDLE, DRAW, DONE.

IDLE:
- If pause=1: stay in IDLE.
- Else if clear_req=1: latch origin (0,0), size SCR_W x SCR_H, CLEAR_COLOUR, mode=CLEAR; go to DRAW. Clear has priority over every lane.
- Else if any req bit is set: round-robin pick of the first set bit searching from last_grant+1 modulo NUM_REQ. Latch that lane's x, y, colour and size BOX_W x BOX_H; set last_grant to the picked lane; go to DRAW.
- Else: stay in IDLE.

DRAW (pause=0):
- Generate pixel (ox+cx, oy+cy) in raster order: cx increments first and wraps at width, then cy increments.
- Outputs are registered. The pixel generated in cycle n appears on vga_* in cycle n+1.
- vga_plot=1 only if the 9-bit sum ox+cx < SCR_W and the 8-bit sum oy+cy < SCR_H. Otherwise vga_plot=0, and vga_x/vga_y carry the truncated sums.
- Clipped pixels still consume one cycle each.
- After the last pixel is generated (cx=w-1, cy=h-1), go to DONE.

DRAW (pause=1):
- Counters hold.
- The next output cycle has vga_plot=0; vga_x, vga_y and vga_colour hold their previous values.

DONE:
- The last pixel is on the outputs this cycle.
- Pulse done[last_grant] or clear_done for exactly one cycle; go to IDLE.

Timing and request rules:
- Timing for a request sampled in IDLE at cycle 0: pixel k is on the outputs at cycle 2+k; the done pulse is at cycle 1+W*H; a new grant is possible at cycle 2+W*H.
- Deasserting req while that lane is in service is ignored; the rectangle completes. Input changes to the lane's x/y/colour after the grant are ignored.
- vga_plot=0 in IDLE and in every cycle not driven by DRAW output.

Decomposition:
- Shared package vga_pkg: state encodings (IDLE, DRAW, DONE), SCR_W/SCR_H constants, and XW=8 / YW=7 width constants.
- Sub-module rr_pick: combinational round-robin selector. Inputs: req vector and last_grant. Outputs: valid and index.
- Everything else stays in vga_plot_arbiter.

Test Plan:
- After reset, req[0]=1 with (10,20), colour 7 → vga_plot=1 for 8 cycles at (10..13,20) then (10..13,21), colour 7, starting at cycle 2; done[0] pulses at cycle 9; busy is high in cycles 1-9.
- req[0] and req[1] held continuously → grants alternate 0,1,0,1; each done pulse is 10 cycles apart; there is no plot overlap.
- req[2] at (158,119) → over 8 cycles only (158,119) and (159,119) have vga_plot=1; the other 6 cycles have plot=0; done[2] pulses at cycle 9.
- clear_req and req[1] asserted together → 19200 plots of colour 000 in raster order, (0,0) first and (159,119) last; clear_done pulses; lane 1 is served afterwards.
- pause=1 for 5 cycles during the 3rd pixel of a lane-0 draw → 5 cycles with plot=0, then the sequence resumes at the 3rd pixel; done[0] is delayed by 5 cycles.
- resetn pulsed during the 4th pixel → all outputs 0 asynchronously and no done pulse; after release, req[1] and req[0] both high → lane 0 is granted first.

Source files
------------

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared definitions for the VGA plot arbiter slice.
//   state_t : arbiter sequencing states (IDLE, DRAW, DONE)
//   SCR_W/SCR_H : adapter resolution
//   XW/YW : adapter x/y coordinate widths
package vga_pkg;

  localparam int unsigned SCR_W = 160;
  localparam int unsigned SCR_H = 120;
  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req        : request vector
//   last_grant : most recently granted index; search starts one above it
//   valid      : at least one request set
//   index      : first set request found searching upward (with wrap)
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic          valid,
  output logic [GW-1:0] index
);

  int unsigned c;

  always_comb begin
    valid = 1'b0;
    index = '0;
    c     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      c = (32'(last_grant) + i) % N;
      if (!valid && req[c]) begin
        valid = 1'b1;
        index = GW'(c);
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter write port between NUM_REQ lane drawers and a
// full-screen clear. Rectangles are emitted one pixel per cycle in raster
// order; off-screen pixels take a cycle but are not plotted.
//   clk, resetn          : clock, asynchronous active-high reset
//   req/req_x/req_y/req_colour : per-lane level requests and packed fields
//   clear_req            : full-screen clear request (beats all lanes)
//   pause                : stall grants and pixel advance
//   done / clear_done    : one-cycle completion pulses
//   busy                 : high while drawing or completing
//   vga_x/vga_y/vga_colour/vga_plot : registered adapter write port
module vga_plot_arbiter
  import vga_pkg::state_t;
  import vga_pkg::IDLE;
  import vga_pkg::DRAW;
  import vga_pkg::DONE;
  import vga_pkg::XW;
  import vga_pkg::YW;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BOX_W        = 4,
  parameter int unsigned BOX_H        = 2,
  parameter int unsigned SCR_W        = vga_pkg::SCR_W,
  parameter int unsigned SCR_H        = vga_pkg::SCR_H,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [XW*NUM_REQ-1:0] req_x,
  input  logic [YW*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0]  req_colour,
  input  logic                  clear_req,
  input  logic                  pause,
  output logic [NUM_REQ-1:0]    done,
  output logic                  clear_done,
  output logic                  busy,
  output logic [XW-1:0]         vga_x,
  output logic [YW-1:0]         vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t        state, state_nx;
  logic [XW-1:0] cx, ox, w;
  logic [YW-1:0] cy, oy, h;
  logic [2:0]    col;
  logic          mode_clear;
  logic [GW-1:0] last_grant;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic          grant, gen, last_px;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  rr_pick #(.N(NUM_REQ), .GW(GW)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  assign sum_x   = {1'b0, ox} + {1'b0, cx};
  assign sum_y   = {1'b0, oy} + {1'b0, cy};
  assign last_px = (cx == w - XW'(1)) && (cy == h - YW'(1));

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gen      = 1'b0;
    unique case (state)
      IDLE: if (!pause && (clear_req || pick_valid)) begin
        grant    = 1'b1;
        state_nx = DRAW;
      end
      DRAW: if (!pause) begin
        gen = 1'b1;
        if (last_px) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    done       = '0;
    clear_done = 1'b0;
    busy       = (state != IDLE);
    if (state == DONE) begin
      if (mode_clear) clear_done = 1'b1;
      else            done[last_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      ox         <= '0;
      oy         <= '0;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      mode_clear <= 1'b0;
      last_grant <= GW'(NUM_REQ - 1);
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state    <= state_nx;
      // Plot only ever follows a generated pixel; coordinates hold otherwise.
      vga_plot <= 1'b0;
      if (grant) begin
        cx <= '0;
        cy <= '0;
        if (clear_req) begin
          ox         <= '0;
          oy         <= '0;
          w          <= XW'(SCR_W);
          h          <= YW'(SCR_H);
          col        <= CLEAR_COLOUR;
          mode_clear <= 1'b1;
        end else begin
          ox         <= req_x[XW*pick_idx +: XW];
          oy         <= req_y[YW*pick_idx +: YW];
          col        <= req_colour[3*pick_idx +: 3];
          w          <= XW'(BOX_W);
          h          <= YW'(BOX_H);
          mode_clear <= 1'b0;
          last_grant <= pick_idx;
        end
      end
      if (gen) begin
        vga_x      <= sum_x[XW-1:0];
        vga_y      <= sum_y[YW-1:0];
        vga_colour <= col;
        vga_plot   <= (sum_x < (XW+1)'(SCR_W)) && (sum_y < (YW+1)'(SCR_H));
        if (cx == w - XW'(1)) begin
          cx <= '0;
          cy <= cy + YW'(1);
        end else begin
          cx <= cx + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
module tb_vga_plot_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NR-1:0] req = '0;
  logic [8*NR-1:0] req_x = '0;
  logic [7*NR-1:0] req_y = '0;
  logic [3*NR-1:0] req_colour = '0;
  logic          clear_req = 1'b0;
  logic          pause = 1'b0;
  logic [NR-1:0] done;
  logic          clear_done, busy, vga_plot;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;

  int n_cmp = 0;
  int n_err = 0;

  vga_plot_arbiter #(.NUM_REQ(NR), .BOX_W(4), .BOX_H(2), .SCR_W(160), .SCR_H(120),
                     .CLEAR_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .clear_req(clear_req), .pause(pause), .done(done),
    .clear_done(clear_done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input int x, input int y, input int c);
    req_x[8*i +: 8]      = 8'(x);
    req_y[7*i +: 7]      = 7'(y);
    req_colour[3*i +: 3] = 3'(c);
  endtask

  // Behavioural model: a job is a list of w*h raster pixels; phase 0 idle,
  // 1 emitting pixel m_k, 2 completion cycle.
  int m_phase = 0, m_job = 0, m_ox = 0, m_oy = 0, m_w = 1, m_h = 1, m_k = 0;
  int m_col = 0, m_last = NR - 1, px, py, lane;
  logic [7:0]    e_x = '0;
  logic [6:0]    e_y = '0;
  logic [2:0]    e_col = '0;
  logic          e_plot = 1'b0, e_cdone = 1'b0, e_busy = 1'b0;
  logic [NR-1:0] e_done = '0;

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      m_phase = 0; m_last = NR - 1; m_job = 0;
      e_x = '0; e_y = '0; e_col = '0; e_plot = 1'b0;
      e_done = '0; e_cdone = 1'b0; e_busy = 1'b0;
    end else begin
      e_plot = 1'b0;
      if (m_phase == 2) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (!pause) begin
          px = m_ox + m_k % m_w;
          py = m_oy + m_k / m_w;
          e_x = 8'(px); e_y = 7'(py); e_col = 3'(m_col);
          e_plot = (px < 160) && (py < 120);
          m_k++;
          if (m_k == m_w * m_h) m_phase = 2;
        end
      end else if (!pause) begin
        if (clear_req) begin
          m_job = -1; m_ox = 0; m_oy = 0; m_w = 160; m_h = 120; m_col = 0;
          m_k = 0; m_phase = 1;
        end else begin
          lane = -1;
          for (int i = 1; i <= NR; i++)
            if (lane < 0 && req[(m_last + i) % NR]) lane = (m_last + i) % NR;
          if (lane >= 0) begin
            m_job = lane; m_last = lane;
            m_ox = int'(req_x[8*lane +: 8]); m_oy = int'(req_y[7*lane +: 7]);
            m_col = int'(req_colour[3*lane +: 3]);
            m_w = 4; m_h = 2; m_k = 0; m_phase = 1;
          end
        end
      end
      e_busy  = (m_phase != 0);
      e_done  = (m_phase == 2 && m_job >= 0) ? NR'(1 << m_job) : '0;
      e_cdone = (m_phase == 2 && m_job < 0);
    end
  end

  always @(negedge clk) begin
    chk("plot", vga_plot, e_plot);
    chk("x", vga_x, e_x);
    chk("y", vga_y, e_y);
    chk("colour", vga_colour, e_col);
    chk("done", done, e_done);
    chk("clear_done", clear_done, e_cdone);
    chk("busy", busy, e_busy);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int k, nplot, tdone, got, tprev, nord, fx, fy, lx, ly;
  bit seen;

  initial begin
    #1 resetn = 1'b1;
    #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_xy", {vga_x, vga_y, vga_colour}, 0);
    @(negedge clk); #2 resetn = 1'b0;

    // Test 1: lane 0 at (10,20) colour 7
    @(negedge clk);
    set_lane(0, 10, 20, 7); req = 4'b0001;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      k = c - 2;
      chk("t1_plot", vga_plot, (c >= 2 && c <= 9));
      if (c >= 2 && c <= 9)
        chk("t1_pix", {vga_x, vga_y, vga_colour}, {8'(10 + k % 4), 7'(20 + k / 4), 3'd7});
      chk("t1_done", done, (c == 9) ? 4'b0001 : 4'b0000);
      chk("t1_busy", busy, (c >= 1 && c <= 9));
      if (c == 9) req = '0;
    end

    // Test 2: lanes 0 and 1 held; last grant was 0 so lane 1 first
    set_lane(1, 40, 60, 2); req = 4'b0011;
    got = 0; tprev = 0;
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(negedge clk);
      if (done != 0) begin
        chk("t2_order", done, (got % 2 == 0) ? 4'b0010 : 4'b0001);
        if (got > 0) chk("t2_gap", c - tprev, 10);
        tprev = c; got++;
        if (got == 4) req = '0;
      end
    end
    chk("t2_count", got, 4);

    // Test 3: lane 2 at bottom-right corner, mostly clipped
    @(negedge clk);
    set_lane(2, 158, 119, 5); req = 4'b0100;
    @(posedge clk);
    nplot = 0; tdone = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (vga_plot) begin
        nplot++;
        chk("t3_pix", {vga_x, vga_y}, {8'(156 + c), 7'd119});
      end
      if (c == 4) chk("t3_clip_x", {vga_plot, vga_x}, {1'b0, 8'd160});
      if (done[2]) begin tdone = c; req = '0; end
    end
    chk("t3_nplot", nplot, 2);
    chk("t3_tdone", tdone, 9);

    // Test 4: clear and lane 1 together; clear wins, lane 1 follows
    @(negedge clk);
    clear_req = 1'b1; req = 4'b0010;
    nplot = 0; nord = 0; seen = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int c = 0; c < 19400 && !seen; c++) begin
      @(negedge clk);
      if (vga_plot) begin
        if (nplot == 0) begin fx = vga_x; fy = vga_y; end
        lx = vga_x; ly = vga_y;
        if (vga_x != 8'(nplot % 160) || vga_y != 7'(nplot / 160) || vga_colour != 3'd0)
          nord++;
        nplot++;
      end
      if (clear_done) begin seen = 1; clear_req = 1'b0; end
    end
    chk("t4_cdone", seen, 1);
    chk("t4_nplot", nplot, 19200);
    chk("t4_order_errs", nord, 0);
    chk("t4_first", {fx[7:0], fy[7:0]}, {8'd0, 8'd0});
    chk("t4_last", {lx[7:0], ly[7:0]}, {8'd159, 8'd119});
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done != 0) begin
        seen = 1; req = '0;
        chk("t4_lane1", done, 4'b0010);
      end
    end
    chk("t4_lane1_seen", seen, 1);

    // Test 5: pause for 5 cycles over the 3rd pixel of a lane-0 draw
    @(negedge clk);
    set_lane(0, 30, 40, 3); req = 4'b0001;
    @(posedge clk);
    nplot = 0; tdone = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("t5_plot", vga_plot, (c == 2 || c == 3 || (c >= 9 && c <= 14)));
      if (vga_plot) nplot++;
      if (c == 9) chk("t5_resume", {vga_x, vga_y}, {8'd32, 7'd40});
      if (done[0]) begin tdone = c; req = '0; end
      if (c == 3) pause = 1'b1;
      if (c == 8) pause = 1'b0;
    end
    chk("t5_nplot", nplot, 8);
    chk("t5_tdone", tdone, 14);

    // Test 6: reset during the 4th pixel, then priority returns to lane 0
    @(negedge clk);
    set_lane(3, 50, 50, 6); set_lane(0, 10, 20, 7); req = 4'b1000;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    chk("t6_pix4", {vga_plot, vga_x, vga_y}, {1'b1, 8'd53, 7'd50});
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    chk("t6_rst_out", {vga_plot, vga_x, vga_y, vga_colour}, 0);
    chk("t6_rst_flags", {done, clear_done, busy}, 0);
    req = '0;
    @(negedge clk); #2 resetn = 1'b0;
    @(negedge clk);
    req = 4'b0011;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done != 0) begin
        seen = 1; req = '0;
        chk("t6_first", done, 4'b0001);
      end
    end
    chk("t6_seen", seen, 1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
